// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial subtractor: number1 - number2, one full-subtractor step per clock, LSB first.
// Outputs are registered and only move at the RUN->DONE edge or on reset.
module n_bit_serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] number1,
  input  logic [N-1:0] number2,
  output logic [N-1:0] result,
  output logic         borrow,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic [N-1:0]   result_q, result_d;
  logic           borrow_q, borrow_d;
  logic           overflow_q, overflow_d;

  logic           a_bit, b_bit, diff_bit, br_nxt;
  logic [N-1:0]   sh_nxt;

  assign a_bit    = a_q[cnt_q];
  assign b_bit    = b_q[cnt_q];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign sh_nxt   = {diff_bit, sh_q[N-1:1]};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    br_d       = br_q;
    result_d   = result_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = number1;
          b_d     = number2;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d  = sh_nxt;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d    = S_DONE;
          result_d   = sh_nxt;
          borrow_d   = br_nxt;
          // Signed overflow: operand signs differ and the result sign departs from the minuend.
          overflow_d = (a_q[N-1] != b_q[N-1]) && (sh_nxt[N-1] != a_q[N-1]);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      br_q       <= 1'b0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      br_q       <= br_d;
      result_q   <= result_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Self-checking bench for n_bit_serial_subtractor (N=8): directed vectors, timing,
// mid-run start and reset, randomized operands against an arithmetic reference model.
module tb_n_bit_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] number1, number2;
  logic [N-1:0] result;
  logic         borrow, overflow, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  n_bit_serial_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .number1  (number1),
    .number2  (number2),
    .result   (result),
    .borrow   (borrow),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, borrow, result} from plain integer arithmetic.
  function automatic logic [N+1:0] ref_sub(input int a, input int b);
    int d, sa, sb, sd;
    logic [N-1:0] r;
    logic bo, ov;
    d  = a - b;
    r  = d[N-1:0];
    bo = (a < b);
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    sd = sa - sb;
    ov = (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
    return {ov, bo, r};
  endfunction

  // Issues one request from IDLE and waits (bounded) for the done pulse.
  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] res, output logic bo, output logic ov,
                        output int lat, output bit to);
    start = 1'b1; number1 = a; number2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    number1 = N'($urandom); number2 = N'($urandom);
    lat = 0; to = 1'b1; res = '0; bo = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; to = 1'b0; res = result; bo = borrow; ov = overflow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; number1 = 8'd5; number2 = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, borrow, overflow, busy, done} !== {8'h00, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_outputs: got res=%h bo=%b ov=%b busy=%b done=%b, want all zero",
               result, borrow, overflow, busy, done);
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [6] = '{8'd90, 8'd18, 8'd0,   8'd53, 8'd127, 8'd128};
    logic [7:0] vb [6] = '{8'd18, 8'd90, 8'd1,   8'd53, 8'd255, 8'd1};
    logic [7:0] er [6] = '{8'h48, 8'hB8, 8'hFF, 8'h00, 8'h80,  8'h7F};
    logic       eb [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,   1'b0};
    logic       eo [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,   1'b1};
    logic [N-1:0] res; logic bo, ov; int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], res, bo, ov, lat, to);
      n_cmp++;
      if (to || res !== er[i] || bo !== eb[i] || ov !== eo[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: %0d-%0d got res=%h bo=%b ov=%b timeout=%0d, want res=%h bo=%b ov=%b",
                 i, va[i], vb[i], res, bo, ov, to, er[i], eb[i], eo[i]);
      end
      n_cmp++;
      if (lat !== N) begin
        n_bad++;
        $display("FAIL latency_%0d: got %0d cycles, want %0d", i, lat, N);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== er[i]) begin
        n_bad++;
        $display("FAIL after_done_%0d: got done=%b busy=%b res=%h, want 0 0 %h",
                 i, done, busy, result, er[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [N-1:0] res = '0; logic bo = 1'b0;
    start = 1'b1; number1 = 8'd21; number2 = 8'd52;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      start = (n == 3);
      if (n == 3) begin number1 = 8'd96; number2 = 8'd53; end
      @(posedge clk); #1;
      if (done) begin pulses++; res = result; bo = borrow; end
    end
    start = 1'b0;
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", pulses);
    end
    n_cmp++;
    if (res !== 8'hE1 || bo !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_start_result: got res=%h bo=%b, want res=e1 bo=1", res, bo);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    logic [N-1:0] res; logic bo, ov; int lat; bit to;
    start = 1'b1; number1 = 8'd200; number2 = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || borrow !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got busy=%b done=%b res=%h bo=%b ov=%b, want 0 0 00 0 0",
               busy, done, result, borrow, overflow);
    end
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d active cycles after reset, want 0", pulses);
    end
    run_op(8'd100, 8'd37, res, bo, ov, lat, to);
    n_cmp++;
    if (to || res !== 8'd63 || bo !== 1'b0 || ov !== 1'b0 || lat !== N) begin
      n_bad++;
      $display("FAIL reset_restart: got res=%h bo=%b ov=%b lat=%0d timeout=%0d, want 3f 0 0 %0d",
               res, bo, ov, lat, to, N);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, res; logic bo, ov; int lat; bit to;
    logic [N+1:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom); b = N'($urandom);
      if (i % 10 == 0) b = a;
      exp = ref_sub(int'(a), int'(b));
      run_op(a, b, res, bo, ov, lat, to);
      n_cmp++;
      if (to || {ov, bo, res} !== exp || lat !== N) begin
        n_bad++;
        $display("FAIL random_%0d: %0d-%0d got res=%h bo=%b ov=%b lat=%0d, want res=%h bo=%b ov=%b lat=%0d",
                 i, a, b, res, bo, ov, lat, exp[N-1:0], exp[N], exp[N+1], N);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int t_first = -1, t_second = -1, pulses = 0;
    logic [N+1:0] exp;
    logic bad_val = 1'b0;
    number1 = 8'd3; number2 = 8'd250;
    exp = ref_sub(3, 250);
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (t_first < 0) t_first = n; else if (t_second < 0) t_second = n;
        if ({overflow, borrow, result} !== exp) bad_val = 1'b1;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t_first < 0 || t_second < 0 || (t_second - t_first) !== N + 2) begin
      n_bad++;
      $display("FAIL back_to_back_interval: got first=%0d second=%0d, want spacing %0d",
               t_first, t_second, N + 2);
    end
    n_cmp++;
    if (bad_val || pulses < 2) begin
      n_bad++;
      $display("FAIL back_to_back_value: got pulses=%0d bad_value=%b, want >=2 pulses res=%h",
               pulses, bad_val, exp[N-1:0]);
    end
    repeat (N + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; number1 = '0; number2 = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
